// File: rtl/mem_resp_pkg.sv
// Shared types and sizing helpers for the memory-side line responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, default geometry, sizing functions.
package mem_resp_pkg;

   // Default geometry (64 B lines, 4 B beats, 256 lines)
   localparam int DEF_BLOCK_SIZE     = 6;
   localparam int DEF_WR_M_DATA_SIZE = 4;
   localparam int DEF_MEM_LINES      = 256;

   localparam int BEATS      = (1 << DEF_BLOCK_SIZE) / DEF_WR_M_DATA_SIZE;
   localparam int BEAT_W     = 8 * DEF_WR_M_DATA_SIZE;
   localparam int LINE_W     = $clog2(DEF_MEM_LINES);
   localparam int BEAT_IDX_W = $clog2(BEATS);

   // State codes kept as plain constants so older code can compare raw bits
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_W_WAIT = 3'd1;
   localparam logic [2:0] ST_W_DATA = 3'd2;
   localparam logic [2:0] ST_R_WAIT = 3'd3;
   localparam logic [2:0] ST_R_DATA = 3'd4;

   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      W_WAIT = ST_W_WAIT,
      W_DATA = ST_W_DATA,
      R_WAIT = ST_R_WAIT,
      R_DATA = ST_R_DATA
   } state_e;

   // Beats per line for a given line size (log2 bytes) and beat size (bytes)
   function automatic int beats_of(input int block_size, input int bytes_per_beat);
      return (1 << block_size) / bytes_per_beat;
   endfunction

   // Index width for n entries, never narrower than one bit
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_line_store.sv
// Single-port synchronous line store, one beat per word.
// Latency: read data valid one cycle after the address is presented.
// Backpressure: none; accepts a read or write every cycle.
// Ports: clk; we/addr/wdata write port; rdata registered read of addr
// (read-before-write when we and the read address coincide).
// The array is deliberately not reset so contents survive rst_n.
module mem_line_store
   import mem_resp_pkg::*;
#(
   parameter int AW = 12,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/mem_line_responder.sv
// Memory-side responder: absorbs write-back bursts / streams load bursts per line.
// Latency: ready_wb at accept+WR_LATENCY (>=1); first valid_ld at accept+RD_LATENCY (>=2).
// Backpressure: load beats stall on ready_ld=0 (valid_ld/rd_data hold); write beats gated by valid_wb_in.
// Ports: clk, rst_n (sync, active-low); request addr_valid_in/rw_in/mem_addr;
//        write beats valid_wb_in/wr_data with ready_wb grant pulse;
//        load beats valid_ld/rd_data with ready_ld.
// Build option MEM_RESP_STATS_EN: adds saturating rd_bursts/wr_bursts counters.
module mem_line_responder
   import mem_resp_pkg::*;
#(
   parameter int ADDR_W         = 16,
   parameter int BLOCK_SIZE     = DEF_BLOCK_SIZE,
   parameter int WR_M_DATA_SIZE = DEF_WR_M_DATA_SIZE,
   parameter int MEM_LINES      = DEF_MEM_LINES,
   parameter int WR_LATENCY     = 2,
   parameter int RD_LATENCY     = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        addr_valid_in,
   input  logic                        rw_in,
   input  logic [ADDR_W-1:0]           mem_addr,
   input  logic                        valid_wb_in,
   input  logic [8*WR_M_DATA_SIZE-1:0] wr_data,
   output logic                        ready_wb,
   input  logic                        ready_ld,
   output logic                        valid_ld,
   output logic [8*WR_M_DATA_SIZE-1:0] rd_data
`ifdef MEM_RESP_STATS_EN
   ,
   output logic [15:0]                 rd_bursts,
   output logic [15:0]                 wr_bursts
`endif
);

   localparam int NBEATS  = beats_of(BLOCK_SIZE, WR_M_DATA_SIZE);
   localparam int DW      = 8 * WR_M_DATA_SIZE;
   localparam int LW      = idx_w(MEM_LINES);
   localparam int BW      = idx_w(NBEATS);
   localparam int MAX_LAT = (WR_LATENCY > RD_LATENCY) ? WR_LATENCY : RD_LATENCY;
   localparam int LAT_W   = idx_w(MAX_LAT + 1);

   localparam logic [BW-1:0]    LAST_BEAT = BW'(NBEATS - 1);
   localparam logic [LAT_W-1:0] WR_GRANT  = LAT_W'(WR_LATENCY - 1);
   localparam logic [LAT_W-1:0] RD_FIRST  = LAT_W'(RD_LATENCY - 1);

   state_e            state;
   logic [LW-1:0]     line_q;
   logic [BW-1:0]     beat;
   logic [LAT_W-1:0]  lat_cnt;

   logic [LW-1:0]     req_line;
   logic              wr_fire;
   logic              rd_fire;
   logic              last_beat;
   logic [LW-1:0]     ram_line;
   logic [BW-1:0]     ram_beat;
   logic [DW-1:0]     ram_q;
   logic              unused_mem_addr;

   // Only the line field matters; offset and upper bits alias away
   assign req_line        = mem_addr[BLOCK_SIZE +: LW];
   assign unused_mem_addr = ^mem_addr;

   // Beats are stored from the grant cycle onward
   assign wr_fire   = valid_wb_in && ((state == W_WAIT && ready_wb) || state == W_DATA);
   assign rd_fire   = (state == R_DATA) && valid_ld && ready_ld;
   assign last_beat = (beat == LAST_BEAT);

   // Store address. The read path runs one beat ahead of rd_data so the next
   // beat is already on ram_q when the current one transfers: beat 0 is read
   // at accept+RD_LATENCY-2, beat 1 the cycle after, then beat+1 (or beat+2
   // when this cycle transfers) while streaming.
   always_comb begin
      ram_line = line_q;
      ram_beat = beat;
      case (state)
         IDLE: begin
            ram_line = req_line;
            ram_beat = '0;
         end
         R_WAIT: ram_beat = (lat_cnt == RD_FIRST) ? BW'(1) : '0;
         R_DATA: ram_beat = rd_fire ? (beat + BW'(2)) : (beat + BW'(1));
         default: ram_beat = beat;
      endcase
   end

   mem_line_store #(
      .AW (LW + BW),
      .DW (DW)
   ) u_store (
      .clk   (clk),
      .we    (wr_fire),
      .addr  ({ram_line, ram_beat}),
      .wdata (wr_data),
      .rdata (ram_q)
   );

   // The request direction is carried by the state itself (W_* vs R_*)
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         ready_wb <= 1'b0;
         valid_ld <= 1'b0;
         rd_data  <= '0;
         beat     <= '0;
         lat_cnt  <= '0;
         line_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (addr_valid_in) begin
                  line_q  <= req_line;
                  lat_cnt <= LAT_W'(1);
                  beat    <= '0;
                  if (rw_in) begin
                     state    <= W_WAIT;
                     ready_wb <= (WR_LATENCY == 1);
                  end else begin
                     state <= R_WAIT;
                  end
               end
            end

            W_WAIT: begin
               lat_cnt <= lat_cnt + LAT_W'(1);
               if (ready_wb) begin
                  ready_wb <= 1'b0;
                  if (wr_fire) begin
                     beat <= last_beat ? '0 : beat + BW'(1);
                  end
                  state <= (wr_fire && last_beat) ? IDLE : W_DATA;
               end else if (lat_cnt == WR_GRANT) begin
                  ready_wb <= 1'b1;
               end
            end

            W_DATA: begin
               if (wr_fire) begin
                  if (last_beat) begin
                     beat  <= '0;
                     state <= IDLE;
                  end else begin
                     beat <= beat + BW'(1);
                  end
               end
            end

            R_WAIT: begin
               lat_cnt <= lat_cnt + LAT_W'(1);
               if (lat_cnt == RD_FIRST) begin
                  valid_ld <= 1'b1;
                  rd_data  <= ram_q;
                  state    <= R_DATA;
               end
            end

            R_DATA: begin
               if (rd_fire) begin
                  if (last_beat) begin
                     valid_ld <= 1'b0;
                     beat     <= '0;
                     state    <= IDLE;
                  end else begin
                     beat    <= beat + BW'(1);
                     rd_data <= ram_q;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

`ifdef MEM_RESP_STATS_EN
   logic wr_done;
   logic rd_done;

   assign wr_done = wr_fire && last_beat;
   assign rd_done = rd_fire && last_beat;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_bursts <= '0;
         wr_bursts <= '0;
      end else begin
         if (wr_done && wr_bursts != 16'hFFFF) begin
            wr_bursts <= wr_bursts + 16'd1;
         end
         if (rd_done && rd_bursts != 16'hFFFF) begin
            rd_bursts <= rd_bursts + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_line_responder.sv
// Self-checking bench for mem_line_responder (default geometry).
// Expected load data comes from a line-store model filled as write beats are driven.
module tb_mem_line_responder;

   localparam int ADDR_W     = 16;
   localparam int BLOCK_SIZE = 6;
   localparam int MEM_LINES  = 256;
   localparam int LINE_W     = 8;
   localparam int BEATS      = 16;
   localparam int WR_LATENCY = 2;
   localparam int RD_LATENCY = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              addr_valid_in;
   logic              rw_in;
   logic [ADDR_W-1:0] mem_addr;
   logic              valid_wb_in;
   logic [31:0]       wr_data;
   logic              ready_wb;
   logic              ready_ld;
   logic              valid_ld;
   logic [31:0]       rd_data;
`ifdef MEM_RESP_STATS_EN
   logic [15:0]       rd_bursts;
   logic [15:0]       wr_bursts;
`endif

   int errors = 0;
   int checks = 0;
   int n_wr   = 0;
   int n_rd   = 0;

   logic [31:0] model [0:MEM_LINES*BEATS-1];
   logic [31:0] exp_q [$];

   always #5 clk = ~clk;

   mem_line_responder dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .addr_valid_in (addr_valid_in),
      .rw_in         (rw_in),
      .mem_addr      (mem_addr),
      .valid_wb_in   (valid_wb_in),
      .wr_data       (wr_data),
      .ready_wb      (ready_wb),
      .ready_ld      (ready_ld),
      .valid_ld      (valid_ld),
      .rd_data       (rd_data)
`ifdef MEM_RESP_STATS_EN
      ,
      .rd_bursts     (rd_bursts),
      .wr_bursts     (wr_bursts)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int line_of(input logic [ADDR_W-1:0] a);
      logic [LINE_W-1:0] l;
      l = a[BLOCK_SIZE +: LINE_W];
      return int'(l);
   endfunction

   // Write-back burst. gap_beat inserts one idle cycle before that beat;
   // rst_after asserts reset once that many beats have been stored.
   task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [31:0] base,
                           input int gap_beat, input int rst_after);
      int k;
      int ln;
      int b;
      int c;
      bit gapped;
      ln = line_of(addr);
      addr_valid_in = 1'b1;
      rw_in         = 1'b1;
      mem_addr      = addr;
      tick();
      addr_valid_in = 1'b0;
      rw_in         = 1'b0;
      k = 1;
      while (!ready_wb && k < 20) begin
         tick();
         k++;
      end
      checks++;
      if (k !== WR_LATENCY) begin
         errors++;
         $display("FAIL wr_latency addr=%h got=%0d cycles expected=%0d", addr, k, WR_LATENCY);
      end
      if (!ready_wb) return;
      b = 0;
      c = 0;
      gapped = 1'b0;
      while (b < BEATS) begin
         if (rst_after >= 0 && b == rst_after) begin
            rst_n       = 1'b0;
            valid_wb_in = 1'b0;
            tick();
            rst_n = 1'b1;
            n_wr  = 0;
            n_rd  = 0;
            return;
         end
         if (b == gap_beat && !gapped) begin
            valid_wb_in = 1'b0;
            wr_data     = 32'hDEAD_BEEF;
            gapped      = 1'b1;
         end else begin
            valid_wb_in = 1'b1;
            wr_data     = base + 32'(b);
            model[ln*BEATS + b] = base + 32'(b);
            b++;
         end
         tick();
         c++;
         if (c == 1) begin
            checks++;
            if (ready_wb !== 1'b0) begin
               errors++;
               $display("FAIL ready_wb_pulse_width got=%b expected=0", ready_wb);
            end
         end
      end
      valid_wb_in = 1'b0;
      wr_data     = '0;
      n_wr++;
   endtask

   // Load burst. stall_beat/stall_len hold ready_ld low on that beat;
   // rst_beat asserts reset while that beat is presented; noise drives a
   // stray write request mid-burst that must be ignored.
   task automatic do_load(input logic [ADDR_W-1:0] addr, input int stall_beat,
                          input int stall_len, input int rst_beat, input bit noise);
      int k;
      int ln;
      int b;
      int stalled;
      int cyc;
      ln = line_of(addr);
      addr_valid_in = 1'b1;
      rw_in         = 1'b0;
      mem_addr      = addr;
      ready_ld      = 1'b1;
      tick();
      addr_valid_in = 1'b0;
      k = 1;
      while (!valid_ld && k < 20) begin
         tick();
         k++;
      end
      checks++;
      if (k !== RD_LATENCY) begin
         errors++;
         $display("FAIL rd_latency addr=%h got=%0d cycles expected=%0d", addr, k, RD_LATENCY);
      end
      if (!valid_ld) return;
      for (int i = 0; i < BEATS; i++) exp_q.push_back(model[ln*BEATS + i]);
      b = 0;
      stalled = 0;
      cyc = 0;
      while (b < BEATS && cyc < 200) begin
         if (!valid_ld) break;
         checks++;
         if (rd_data !== exp_q[0]) begin
            errors++;
            $display("FAIL rd_data addr=%h beat=%0d got=%h expected=%h", addr, b, rd_data, exp_q[0]);
         end
         if (b == rst_beat) begin
            rst_n    = 1'b0;
            ready_ld = 1'b0;
            tick();
            rst_n    = 1'b1;
            ready_ld = 1'b1;
            checks++;
            if (valid_ld !== 1'b0 || rd_data !== 32'h0 || ready_wb !== 1'b0) begin
               errors++;
               $display("FAIL reset_mid_load got valid_ld=%b rd_data=%h ready_wb=%b expected 0/0/0",
                        valid_ld, rd_data, ready_wb);
            end
            exp_q.delete();
            n_wr = 0;
            n_rd = 0;
            return;
         end
         addr_valid_in = noise && (b < BEATS - 2);
         rw_in         = noise;
         if (b == stall_beat && stalled < stall_len) begin
            ready_ld = 1'b0;
            stalled++;
         end else begin
            ready_ld = 1'b1;
            void'(exp_q.pop_front());
            b++;
         end
         tick();
         cyc++;
      end
      addr_valid_in = 1'b0;
      rw_in         = 1'b0;
      ready_ld      = 1'b1;
      checks++;
      if (b !== BEATS) begin
         errors++;
         $display("FAIL rd_beat_count addr=%h got=%0d expected=%0d", addr, b, BEATS);
      end
      checks++;
      if (valid_ld !== 1'b0) begin
         errors++;
         $display("FAIL valid_ld_after_burst got=%b expected=0", valid_ld);
      end
      exp_q.delete();
      n_rd++;
   endtask

   task automatic test_reset();
      rst_n         = 1'b0;
      addr_valid_in = 1'b0;
      rw_in         = 1'b0;
      mem_addr      = '0;
      valid_wb_in   = 1'b0;
      wr_data       = '0;
      ready_ld      = 1'b1;
      repeat (3) tick();
      checks++;
      if (ready_wb !== 1'b0 || valid_ld !== 1'b0 || rd_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs got ready_wb=%b valid_ld=%b rd_data=%h expected 0/0/0",
                  ready_wb, valid_ld, rd_data);
      end
`ifdef MEM_RESP_STATS_EN
      checks++;
      if (rd_bursts !== 16'd0 || wr_bursts !== 16'd0) begin
         errors++;
         $display("FAIL reset_stats got rd=%0d wr=%0d expected 0/0", rd_bursts, wr_bursts);
      end
`endif
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_write_back();
      do_write(16'h0140, 32'h1000_0000, -1, -1);
   endtask

   // Issued straight after the write: also covers write-then-read of one line
   task automatic test_load();
      do_load(16'h0140, -1, 0, -1, 1'b0);
   endtask

   task automatic test_stall();
      do_load(16'h0140, 3, 2, -1, 1'b1);
   endtask

   task automatic test_alias();
      do_write(16'h4000, 32'hA5A5_0000, 6, -1);
      do_load(16'h0000, -1, 0, -1, 1'b0);
   endtask

   task automatic test_back_to_back();
      do_write(16'h0180, 32'h3000_0000, -1, -1);
      do_write(16'h01C0, 32'h4000_0000, 0, -1);
      do_load(16'h0180, 15, 1, -1, 1'b0);
      do_load(16'h01C0, -1, 0, -1, 1'b0);
   endtask

   task automatic test_reset_mid_load();
      do_load(16'h0140, -1, 0, 7, 1'b0);
      do_load(16'h0140, -1, 0, -1, 1'b0);
   endtask

   // Beats 0..4 take the new data, 5..15 keep the earlier write-back
   task automatic test_partial_write();
      do_write(16'h0140, 32'h2000_0000, -1, 5);
      do_load(16'h0140, -1, 0, -1, 1'b0);
   endtask

`ifdef MEM_RESP_STATS_EN
   task automatic test_stats();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      n_wr  = 0;
      n_rd  = 0;
      do_write(16'h0200, 32'h5000_0000, -1, -1);
      do_write(16'h0240, 32'h6000_0000, -1, -1);
      do_load(16'h0200, -1, 0, -1, 1'b0);
      do_load(16'h0240, 2, 3, -1, 1'b0);
      do_load(16'h0200, -1, 0, -1, 1'b0);
      checks++;
      if (wr_bursts !== 16'(n_wr) || rd_bursts !== 16'(n_rd)) begin
         errors++;
         $display("FAIL stats_counts got wr=%0d rd=%0d expected wr=%0d rd=%0d",
                  wr_bursts, rd_bursts, n_wr, n_rd);
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++;
      if (wr_bursts !== 16'd0 || rd_bursts !== 16'd0) begin
         errors++;
         $display("FAIL stats_reset got wr=%0d rd=%0d expected 0/0", wr_bursts, rd_bursts);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_write_back();
      test_load();
      test_stall();
      test_alias();
      test_back_to_back();
      test_reset_mid_load();
      test_partial_write();
`ifdef MEM_RESP_STATS_EN
      test_stats();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule
